// File: rtl/register_file_pkg.sv
// riscv_pkg: shared datapath constants and types for the register file and ALU
package riscv_pkg;
  localparam int XLEN       = 64;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/register_file_rf_read_port.sv
// rf_read_port: one combinational read port (index mux, x0 zero-force, write-through under REGFILE_BYPASS_EN)
module rf_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int DEPTH  = NUM_REGS,
  parameter int IDX_W  = REG_ADDR_W
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] regs,
  input  logic [IDX_W-1:0]             addr,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            data
);
  logic bypass;
`ifdef REGFILE_BYPASS_EN
  assign bypass = wr_en && (wr_addr == addr);
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data};
  assign bypass = 1'b0;
`endif
  // x0 always reads zero; otherwise an in-flight write (bypass build only) beats stored data
  always_comb data = (addr == '0) ? '0 : bypass ? wr_data : regs[addr];
endmodule

// File: rtl/register_file.sv
// register_file: 32 x 64-bit RISC-V integer registers, x0 hardwired to zero; same-cycle write-through under REGFILE_BYPASS_EN
module register_file
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int ADDR_W   = riscv_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              rd_we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic [31:0]       wr_count
);
  logic [NUM_REGS-1:0][XLEN-1:0] regs;
  logic                          wr_en;
  logic                          wr_live;
  assign wr_en   = rd_we && (rd_addr != '0);
  assign wr_live = wr_en && rst_n;
  // reset clears everything and drops a coincident write; x0 writes are discarded and not counted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs     <= '0;
      wr_count <= '0;
    end else if (wr_en) begin
      regs[rd_addr] <= rd_data;
      wr_count      <= wr_count + 32'd1;
    end
  end
  rf_read_port #(.DATA_W(XLEN), .DEPTH(NUM_REGS), .IDX_W(ADDR_W)) u_rs1 (
    .regs(regs), .addr(rs1_addr), .wr_en(wr_live), .wr_addr(rd_addr), .wr_data(rd_data), .data(rs1_data)
  );
  rf_read_port #(.DATA_W(XLEN), .DEPTH(NUM_REGS), .IDX_W(ADDR_W)) u_rs2 (
    .regs(regs), .addr(rs2_addr), .wr_en(wr_live), .wr_addr(rd_addr), .wr_data(rd_data), .data(rs2_data)
  );
  rf_read_port #(.DATA_W(XLEN), .DEPTH(NUM_REGS), .IDX_W(ADDR_W)) u_dbg (
    .regs(regs), .addr(dbg_addr), .wr_en(wr_live), .wr_addr(rd_addr), .wr_data(rd_data), .data(dbg_data)
  );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file against an array-based reference model
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic [63:0] rs1_data, rs2_data, rd_data, dbg_data;
  logic        rd_we;
  logic [31:0] wr_count;

  register_file dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int kind; logic [63:0] exp;} exp_t;
  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] mdl[32];
  logic [31:0] mcount;
  string       names[6] = '{"rs1_data", "rs2_data", "dbg_data", "wr_count", "alu_add", "alu_zero"};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rd(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (rd_we && rst_n && rd_addr != 5'd0 && idx == rd_addr) return rd_data;
`endif
    return mdl[idx];
  endfunction

  function automatic void push(input int kind, input logic [63:0] e);
    exp_t x;
    x.cyc = cyc; x.kind = kind; x.exp = e;
    q.push_back(x);
  endfunction

  task automatic step(input logic rn, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad, input int alu);
    rst_n = rn; rd_we = we; rd_addr = wa; rd_data = wd;
    rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
    if (rn) begin
      push(0, rd(a1));
      push(1, rd(a2));
      push(2, rd(ad));
      push(3, {32'd0, mcount});
      if (alu == 4) push(4, rd(a1) + rd(a2));
      if (alu == 5) push(5, {63'd0, (rd(a1) - rd(a2)) == 64'd0});
    end
    if (!rn) begin
      foreach (mdl[i]) mdl[i] = 64'd0;
      mcount = 32'd0;
    end else if (we && wa != 5'd0) begin
      mdl[wa] = wd;
      mcount  = mcount + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: pops every expectation issued for the current cycle and compares it to the live outputs
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t        e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.kind)
        0: act = rs1_data;
        1: act = rs2_data;
        2: act = dbg_data;
        3: act = {32'd0, wr_count};
        4: act = rs1_data + rs2_data;
        default: act = {63'd0, (rs1_data - rs2_data) == 64'd0};
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", names[e.kind], cyc, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rd_we = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 5'd0, 64'd0, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'(i), 0);
    step(1'b1, 1'b1, 5'd5, 64'h0000_0000_0000_00FF, 5'd0, 5'd0, 5'd5, 0);
    step(1'b1, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 5'd6, 5'd6, 0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd6, 5'd0, 0);
    step(1'b1, 1'b1, 5'd0, 64'hDEAD_BEEF, 5'd0, 5'd0, 5'd0, 0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd5, 5'd0, 0);
    step(1'b1, 1'b1, 5'd7, 64'd100, 5'd1, 5'd2, 5'd3, 0);
    step(1'b1, 1'b1, 5'd7, 64'd150, 5'd7, 5'd7, 5'd7, 0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd7, 5'd6, 5'd7, 0);
    step(1'b0, 1'b1, 5'd3, 64'd42, 5'd3, 5'd3, 5'd3, 0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd3, 5'd7, 5'd3, 0);
    step(1'b1, 1'b1, 5'd1, 64'd5, 5'd0, 5'd0, 5'd0, 0);
    step(1'b1, 1'b1, 5'd2, 64'd10, 5'd0, 5'd0, 5'd1, 0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 5'd2, 4);
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd1, 5'd1, 5'd0, 5);
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  wa;
      logic [63:0] wd;
      wa = 5'($urandom_range(7));
      wd = {$urandom, $urandom};
      step($urandom_range(59) != 0, 1'($urandom), wa, wd,
           ($urandom_range(2) == 0) ? wa : 5'($urandom_range(7)),
           ($urandom_range(2) == 0) ? wa : 5'($urandom_range(31)),
           ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31)), 0);
    end
    rd_we = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file for the single-cycle 64-bit RISC-V datapath. It sits directly upstream of the ALU: read port 1 drives ALU operand `a`, and read port 2 drives ALU operand `b` through the immediate mux. The write port takes the write-back result (ALU result, load data or PC+4) at the end of each instruction's cycle. It holds 32 × 64-bit registers with `x0` hardwired to zero.

## Interface
Parameters:
- `XLEN`, 64, register width in bits; must match ALU operand width.
- `NUM_REGS`, 32, number of architectural registers.
- `ADDR_W`, 5, register index width; equals clog2(`NUM_REGS`).

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `rs1_addr`  input  `ADDR_W`  read port 1 index.
- `rs2_addr`  input  `ADDR_W`  read port 2 index.
- `rs1_data`  output  `XLEN`  read port 1 data; feeds ALU `a`.
- `rs2_data`  output  `XLEN`  read port 2 data; feeds ALU `b` or the store-data path.
- `rd_we`  input  1  write enable, from the control unit's RegWrite.
- `rd_addr`  input  `ADDR_W`  write index.
- `rd_data`  input  `XLEN`  write-back data.
- `dbg_addr`  input  `ADDR_W`  debug/testbench read index.
- `dbg_data`  output  `XLEN`  debug read data; same read semantics as the ports above.
- `wr_count`  output  32  count of committed writes to non-zero registers.

## Operation
- Reads are combinational: `rs1_data` = regs[`rs1_addr`], with no clock involved.
- Any read of index 0 returns 64'h0 on every port, regardless of write history.
- Write behaviour:
  - At a rising edge with `rst_n`=1, `rd_we`=1 and `rd_addr`≠0: regs[`rd_addr`] ← `rd_data`, and `wr_count` increments by 1.
  - Writes to index 0 are discarded and do not increment `wr_count`.
  - With `rd_we`=0, no state changes.
- `wr_count` wraps from 32'hFFFF_FFFF to 0 silently.
- The write port is the only source of register updates. No partial or byte writes; the full `XLEN` is always written.
- Read-during-write to the same index is controlled by `REGFILE_BYPASS_EN` (see Configuration).
- Two read ports may address the same register; both return the same value.

## Timing
- Read latency is 0 cycles (combinational from address to data).
- Write latency is 1 cycle: data is visible on reads after the rising edge that commits it.
- Reset:
  - A rising edge with `rst_n`=0 clears all `NUM_REGS` registers and `wr_count` to 0 in that single cycle.
  - After that edge, `rs1_data`, `rs2_data` and `dbg_data` read 0 and `wr_count`=0.
  - Before the first reset edge, contents are undefined; the bench must not check them.
- Reset asserted while `rd_we`=1: reset wins, and the write is dropped.
- Reset mid-program: all architectural state is lost, and no write from the reset cycle survives.
- Simultaneous write and read of the same non-zero index: the result depends on the macro and is fully defined below. Reads of other indices are unaffected.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - Each read port (including debug) compares its index against `rd_addr`.
  - If `rd_we`=1, `rd_addr`≠0, `rst_n`=1 and the indices match, the port returns `rd_data` combinationally in the same cycle (write-through).
  - This is used when the file is reused behind a pipelined front end.
- Undefined:
  - Reads return the stored value, i.e. the old value, until the write edge.
  - This is the default for the single-cycle core, where write-back and operand read of the same instruction must not alias.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`, `NUM_REGS`, `REG_ADDR_W` constants.
  - `reg_addr_t` typedef (logic [REG_ADDR_W-1:0]) and `xlen_t` typedef (logic [XLEN-1:0]).
  - The ALU uses `xlen_t` for its operands and result.
- One sub-module, `rf_read_port`, instantiated three times (rs1, rs2, dbg). It contains:
  - the index mux,
  - the x0 zero-force,
  - the bypass compare, under the macro.
- Storage array, write logic and `wr_count` live in the top module.

## Test plan
- Reset: hold `rst_n`=0 for 1 edge → all 32 `dbg_data` reads = 0 and `wr_count`=0.
- Basic write/read:
  - Write x5 ← 64'h0000_0000_0000_00FF, then x6 ← 64'hFFFF_FFFF_FFFF_FFFF.
  - Next cycle, `rs1_addr`=5, `rs2_addr`=6 → `rs1_data`=64'hFF, `rs2_data`=all ones, `wr_count`=2.
- x0 protection: write x0 ← 64'hDEAD_BEEF → `rs1_data` for index 0 = 0 and `wr_count` unchanged.
- Same-cycle read/write: with x7 = 100, drive `rd_we`=1, `rd_addr`=7, `rd_data`=150, `rs1_addr`=7.
  - Bypass defined → 150 before the edge.
  - Bypass undefined → 100 before the edge.
  - After the edge → 150 in both builds.
- Reset vs write: `rst_n`=0 with `rd_we`=1, `rd_addr`=3, `rd_data`=42 → after the edge, x3 = 0 and `wr_count`=0.
- ALU hookup: write x1=5, x2=10.
  - Read rs1=1, rs2=2 into ALU ADD (4'b0010) → result 15.
  - SUB (4'b0110) with rs1=rs2=1 → zero flag = 1.
